// File: rtl/sram_mem_controller.sv
// MEM-stage data memory controller for a 16-bit asynchronous SRAM: each 32-bit access is two
// halfword phases. Optional last-read buffer is compiled in with `define SRAM_READ_BUFFER_EN.
module sram_mem_controller #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memRead,
    input  logic               memWrite,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_t;

    state_t             stateQ, stateD;
    logic [CntW-1:0]    cntQ, cntD;
    logic               opWriteQ;
    logic [SRAM_AW-2:0] wordQ;
    logic [31:0]        wdataQ;

    logic [31:0]        offset;
    logic [SRAM_AW-2:0] reqWord;
    logic               inXfer;
    logic               phaseEnd;
    logic               start;
    logic               hit;
    logic               unusedBits;

    // Offset wraps modulo 2^32; bits beyond the SRAM window alias.
    assign offset     = address - BASE_ADDR;
    assign reqWord    = offset[SRAM_AW:2];
    assign unusedBits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign inXfer   = (stateQ == StLo) || (stateQ == StHi);
    assign phaseEnd = inXfer && (cntQ == CntMax);
    assign start    = (stateQ == StIdle) && (memRead || memWrite) && !hit;

`ifdef SRAM_READ_BUFFER_EN
    logic [SRAM_AW-2:0] tagQ;
    logic               tagValidQ;

    assign hit = memRead && !memWrite && tagValidQ && (tagQ == reqWord);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tagQ      <= '0;
            tagValidQ <= 1'b0;
        end else if (start && memWrite) begin
            tagValidQ <= 1'b0;
        end else if (stateQ == StDone && !opWriteQ) begin
            tagQ      <= wordQ;
            tagValidQ <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        ready  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                ready = !(memRead || memWrite) || hit;
                if (start) begin
                    stateD = StLo;
                    cntD   = '0;
                end
            end
            StLo, StHi: begin
                if (cntQ == CntMax) begin
                    cntD   = '0;
                    stateD = (stateQ == StLo) ? StHi : StDone;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            StDone: begin
                ready  = 1'b1;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            opWriteQ <= 1'b0;
            wordQ    <= '0;
            wdataQ   <= '0;
            readData <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (start) begin
                opWriteQ <= memWrite;
                wordQ    <= reqWord;
                wdataQ   <= writeData;
            end
            if (phaseEnd && !opWriteQ) begin
                if (stateQ == StLo) begin
                    readData[15:0] <= sram_dq_in;
                end else begin
                    readData[31:16] <= sram_dq_in;
                end
            end
        end
    end

    // SRAM pins decode straight from state so reset parks the bus immediately.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (inXfer) begin
            sram_addr = {wordQ, stateQ == StHi};
            if (opWriteQ) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (stateQ == StHi) ? wdataQ[31:16] : wdataQ[15:0];
                sram_we_n   = !phaseEnd;
            end
        end
    end

endmodule
